ds1302_responder: RTL and testbench
===================================

DS1302_RESPONDER -- requirements
Module: ds1302_responder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, ds1302_clk frequency in Hz, used to derive the internal 1 Hz tick.
REQ-002 SHALL have port ds1302_clk  input  1  the only clock; every flop is on its rising edge.
REQ-003 SHALL have port ds1302_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ds1302_ce  input  1  chip enable from host; high means a transfer is active.
REQ-005 SHALL have port ds1302_sclk  input  1  serial clock from host, SPI mode 0.
REQ-006 SHALL have port ds1302_io  inout  1  bidirectional data, LSB first; driven only during read data phase, else hi-Z.
REQ-007 SHALL have port xfer_done  output  1  one-cycle pulse when a valid single-byte transfer completes.
REQ-008 SHALL have port xfer_cmd  output  8  command byte of the last completed transfer.
REQ-009 SHALL have port xfer_data  output  8  data byte written or read in the last completed transfer.

Function
REQ-010 SHALL pass ds1302_ce, ds1302_sclk and ds1302_io through 2-flop synchronisers and detect SCLK rise/fall edges from the synchronised value; edge detect latency <= 3 cycles.
REQ-011 SHALL implement FSM states IDLE, CMD, WR_DATA, RD_DATA, HOLD.
REQ-012 SHALL go IDLE->CMD on synchronised CE rising; CMD shifts 8 bits on SCLK rises, LSB first.
REQ-013 Command decode: bit7=1 is required, bit6=1 selects RAM, bits5:1 are address, bit0=1 is read; a command with bit7=0 or address 31 (burst) SHALL go to HOLD with no side effect.
REQ-014 SHALL go CMD->WR_DATA on write and shift 8 data bits on SCLK rises; the register SHALL update the cycle after the 8th rise; then go to HOLD.
REQ-015 SHALL go CMD->RD_DATA on read; at each SCLK fall (first fall after 8th command rise) it drives the next bit, bit0 first; after the fall following the 8th bit the line SHALL go hi-Z; then go to HOLD.
REQ-016 In HOLD, SHALL ignore further SCLK edges until CE falls.
REQ-017 A CE fall in any state SHALL force IDLE and release ds1302_io within 3 cycles; a partial write is discarded and xfer_done is not pulsed.
REQ-018 Clock map: 0 sec (bit7 CH), 1 min, 2 hour (24h BCD only), 3 date, 4 month, 5 day, 6 year, 7 control (bit7 WP).
REQ-019 Unmapped clock addresses 8..30 SHALL read 0x00; writes to them are ignored.
REQ-020 With WP=1, writes SHALL be ignored except writes to address 7.
REQ-021 With CH=0, the 1 Hz tick SHALL increment seconds in BCD 00..59; wrap carries into minutes 00..59, which carries into hours 00..23; date and above do not advance.
REQ-022 With CH=1, seconds, minutes and hours SHALL not advance.
REQ-023 If a host write and a tick hit the same register in the same cycle, the host write SHALL win.
REQ-024 xfer_done, xfer_cmd and xfer_data SHALL update in the same cycle as the write commit or read release.

Reset
REQ-025 On reset: FSM=IDLE, ds1302_io hi-Z, xfer_done=0, xfer_cmd=0x00, xfer_data=0x00, seconds=0x80 (halted), other clock regs=0x00, control=0x00, tick counter=0, RAM=0x00.

Configuration
REQ-026 With DS1302_RAM_EN defined, 31 bytes of RAM SHALL be present at bit6=1, addresses 0..30, subject to WP.
REQ-027 Without DS1302_RAM_EN, RAM reads SHALL return 0x00 and RAM writes are ignored; xfer_done still pulses.

Structure
REQ-028 A shared package ds1302_pkg SHALL hold the FSM state encoding, register address constants and the CH/WP bit positions.
REQ-029 The BCD time counter SHALL be sub-module ds1302_time_counter; the serial FSM stays in the top.

Verification
REQ-030 Write cmd 0x80, data 0x45 -> seconds=0x45, CH=0; xfer_done pulses once with xfer_cmd=0x80, xfer_data=0x45.
REQ-031 Write 0x82=0x59, 0x80=0x59, then one tick -> read 0x81 returns 0x00 and 0x83 returns 0x00; hours 0x01.
REQ-032 Write 0x8E=0x80, then write 0x84=0x12 -> hours unchanged; write 0x8E=0x00 succeeds.
REQ-033 Drop CE after 12 SCLK rises of write 0x86 -> date unchanged, no xfer_done, io hi-Z.
REQ-034 Read 0x81 with 4 extra SCLK cycles -> io hi-Z after 8th data bit; extra edges ignored.
REQ-035 With DS1302_RAM_EN, write 0xC0=0xA5 then read 0xC1 -> 0xA5; without it -> 0x00.

Source files
------------

// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 responder: FSM encoding, register map, control bit positions.
package ds1302_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_DATA,
        HOLD
    } state_t;

    localparam logic [2:0] ADDR_SEC   = 3'd0;
    localparam logic [2:0] ADDR_MIN   = 3'd1;
    localparam logic [2:0] ADDR_HOUR  = 3'd2;
    localparam logic [2:0] ADDR_DATE  = 3'd3;
    localparam logic [2:0] ADDR_MONTH = 3'd4;
    localparam logic [2:0] ADDR_DAY   = 3'd5;
    localparam logic [2:0] ADDR_YEAR  = 3'd6;
    localparam logic [2:0] ADDR_CTRL  = 3'd7;
    localparam logic [4:0] ADDR_BURST = 5'd31;

    localparam int CH_BIT        = 7;
    localparam int WP_BIT        = 7;
    localparam int CMD_VALID_BIT = 7;
    localparam int CMD_RAM_BIT   = 6;
    localparam int CMD_READ_BIT  = 0;

    localparam logic [7:0] SEC_RESET = 8'h80;

    // Increment a two-digit BCD value, returning 0 once it reaches max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/ds1302_time_counter.sv
// Clock/control register file with the free-running 1 Hz tick and BCD sec/min/hour chain.
module ds1302_time_counter
    import ds1302_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wp
);

    localparam int CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] tick_cnt;
    logic [7:0]       regs [0:7];
    logic             tick;
    logic             run;
    logic             sec_wrap;
    logic             min_wrap;

    assign tick     = (tick_cnt == CNT_LAST);
    assign run      = tick && !regs[ADDR_SEC][CH_BIT];
    assign sec_wrap = (regs[ADDR_SEC] == 8'h59);
    assign min_wrap = (regs[ADDR_MIN] == 8'h59);

    // Host write is applied last so it overrides a coincident tick update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            for (int i = 0; i < 8; i++)
                regs[i] <= (i == int'(ADDR_SEC)) ? SEC_RESET : 8'h00;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (run) begin
                regs[ADDR_SEC] <= bcd_inc(regs[ADDR_SEC], 8'h59);
                if (sec_wrap) begin
                    regs[ADDR_MIN] <= bcd_inc(regs[ADDR_MIN], 8'h59);
                    if (min_wrap)
                        regs[ADDR_HOUR] <= bcd_inc(regs[ADDR_HOUR], 8'h23);
                end
            end
            if (wr_en)
                regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs[rd_addr];
    assign wp      = regs[ADDR_CTRL][WP_BIT];

endmodule

// File: rtl/ds1302_responder.sv
// DS1302-style 3-wire serial responder: synchronised single-byte transfer FSM over the RTC registers.
// Define DS1302_RAM_EN to add the 31-byte scratch RAM at command bit6=1.
module ds1302_responder
    import ds1302_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       ds1302_clk,
    input  logic       ds1302_rst_n,
    input  logic       ds1302_ce,
    input  logic       ds1302_sclk,
    inout  wire        ds1302_io,
    output logic       xfer_done,
    output logic [7:0] xfer_cmd,
    output logic [7:0] xfer_data
);

    state_t     state;
    logic       ce_p0, ce_p1, ce_p2;
    logic       sclk_p0, sclk_p1, sclk_p2;
    logic       io_p0, io_p1;
    logic       ce_rise, sclk_rise, sclk_fall;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] shift_in;
    logic [7:0] cmd;
    logic [7:0] rd_byte;
    logic [7:0] rd_value;
    logic [7:0] clk_rd;
    logic [7:0] ram_rd;
    logic       io_out;
    logic       io_oe;
    logic       wp;
    logic       wr_fire;
    logic       clk_wr;

    // Synchroniser stage: io shares the sclk depth so sampled data lines up with the detected edge.
    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            ce_p0   <= 1'b0;
            ce_p1   <= 1'b0;
            ce_p2   <= 1'b0;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            io_p0   <= 1'b0;
            io_p1   <= 1'b0;
        end else begin
            ce_p0   <= ds1302_ce;
            ce_p1   <= ce_p0;
            ce_p2   <= ce_p1;
            sclk_p0 <= ds1302_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            io_p0   <= ds1302_io;
            io_p1   <= io_p0;
        end
    end

    assign ce_rise   = ce_p1 & ~ce_p2;
    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign shift_in  = {io_p1, shift[7:1]};

    assign wr_fire = ce_p1 && (state == WR_DATA) && sclk_rise && (bit_cnt == 4'd7);
    assign clk_wr  = wr_fire && !cmd[CMD_RAM_BIT] && (cmd[5:4] == 2'b00)
                     && (!wp || (cmd[3:1] == ADDR_CTRL));

`ifdef DS1302_RAM_EN
    logic [7:0] ram [0:30];
    logic       ram_wr;

    assign ram_wr = wr_fire && cmd[CMD_RAM_BIT] && !wp;

    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            for (int i = 0; i < 31; i++)
                ram[i] <= 8'h00;
        end else if (ram_wr) begin
            ram[cmd[5:1]] <= shift_in;
        end
    end

    assign ram_rd = ram[shift_in[5:1]];
`else
    assign ram_rd = 8'h00;
`endif

    // Read data is chosen from the command byte as it completes on the 8th rise.
    always_comb begin
        rd_value = 8'h00;
        if (shift_in[CMD_RAM_BIT])
            rd_value = ram_rd;
        else if (shift_in[5:4] == 2'b00)
            rd_value = clk_rd;
    end

    ds1302_time_counter #(
        .CLK_FREQ(CLK_FREQ)
    ) u_time_counter (
        .clk    (ds1302_clk),
        .rst_n  (ds1302_rst_n),
        .wr_en  (clk_wr),
        .wr_addr(cmd[3:1]),
        .wr_data(shift_in),
        .rd_addr(shift_in[3:1]),
        .rd_data(clk_rd),
        .wp     (wp)
    );

    // Transfer FSM stage: a CE drop overrides every state.
    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            cmd       <= 8'h00;
            rd_byte   <= 8'h00;
            io_out    <= 1'b0;
            io_oe     <= 1'b0;
            xfer_done <= 1'b0;
            xfer_cmd  <= 8'h00;
            xfer_data <= 8'h00;
        end else begin
            xfer_done <= 1'b0;
            if (!ce_p1) begin
                state   <= IDLE;
                io_oe   <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ce_rise) begin
                            state   <= CMD;
                            bit_cnt <= 4'd0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            shift   <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                cmd     <= shift_in;
                                bit_cnt <= 4'd0;
                                if (!shift_in[CMD_VALID_BIT] || (shift_in[5:1] == ADDR_BURST))
                                    state <= HOLD;
                                else if (shift_in[CMD_READ_BIT]) begin
                                    state   <= RD_DATA;
                                    rd_byte <= rd_value;
                                end else
                                    state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sclk_rise) begin
                            shift   <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                state     <= HOLD;
                                xfer_done <= 1'b1;
                                xfer_cmd  <= cmd;
                                xfer_data <= shift_in;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (sclk_fall) begin
                            if (bit_cnt == 4'd8) begin
                                io_oe     <= 1'b0;
                                state     <= HOLD;
                                xfer_done <= 1'b1;
                                xfer_cmd  <= cmd;
                                xfer_data <= rd_byte;
                            end else begin
                                io_oe   <= 1'b1;
                                io_out  <= rd_byte[bit_cnt[2:0]];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ds1302_io = io_oe ? io_out : 1'bz;

endmodule

// File: tb/tb_ds1302_responder.sv
// Directed bench for ds1302_responder: table of single-byte transfers plus tick, abort and overrun sequences.
module tb_ds1302_responder;

    localparam int P = 2000;
    localparam int H = 8;
`ifdef DS1302_RAM_EN
    localparam logic [7:0] RAM_EXP = 8'hA5;
`else
    localparam logic [7:0] RAM_EXP = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic       sclk = 1'b0;
    logic       host_oe = 1'b0;
    logic       host_bit = 1'b0;
    wire        io;
    logic       xfer_done;
    logic [7:0] xfer_cmd;
    logic [7:0] xfer_data;

    assign io = host_oe ? host_bit : 1'bz;
    pullup (io);

    ds1302_responder #(
        .CLK_FREQ(P)
    ) dut (
        .ds1302_clk  (clk),
        .ds1302_rst_n(rst_n),
        .ds1302_ce   (ce),
        .ds1302_sclk (sclk),
        .ds1302_io   (io),
        .xfer_done   (xfer_done),
        .xfer_cmd    (xfer_cmd),
        .xfer_data   (xfer_data)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    logic [7:0] last_cmd = 8'h00;
    logic [7:0] last_data = 8'h00;

    always @(posedge clk) if (rst_n) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (xfer_done) begin
            done_cnt  = done_cnt + 1;
            last_cmd  = xfer_cmd;
            last_data = xfer_data;
        end
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] wd;
        logic [7:0] exp;
        int         done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            host_oe  = 1'b1;
            host_bit = b[i];
            tick(H);
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
        end
    endtask

    task automatic recv(output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick(H);
            b[i] = io;
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] c, input logic [7:0] wd, output logic [7:0] rd);
        rd = 8'h00;
        ce = 1'b1;
        tick(H);
        send(c, 8);
        if (c[0]) begin
            host_oe = 1'b0;
            recv(rd);
        end else begin
            send(wd, 8);
        end
        host_oe = 1'b0;
        tick(H);
        ce = 1'b0;
        tick(2 * H);
    endtask

    task automatic wait_phase(input int ph);
        tick(1);
        while ((cyc % P) != ph) tick(1);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] c, input logic [7:0] exp);
        logic [7:0] rd;
        xfer(c, 8'h00, rd);
        check(name, rd, exp);
    endtask

    task automatic read_extra(input string name, input logic [7:0] c, input logic [7:0] exp);
        logic [7:0] rd;
        int d0;
        d0 = done_cnt;
        ce = 1'b1;
        tick(H);
        send(c, 8);
        host_oe = 1'b0;
        recv(rd);
        check({name, " data"}, rd, exp);
        tick(4);
        check({name, " io released"}, {7'b0, io}, 8'h01);
        for (int k = 0; k < 4; k++) begin
            tick(H);
            sclk = 1'b1;
            tick(H);
            check({name, " io idle on extra edge"}, {7'b0, io}, 8'h01);
            sclk = 1'b0;
        end
        tick(H);
        ce = 1'b0;
        tick(2 * H);
        check({name, " done count"}, 8'(done_cnt - d0), 8'h01);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int d0;

        vecs.push_back('{8'h81, 8'h00, 8'h80, 1});
        vecs.push_back('{8'h8F, 8'h00, 8'h00, 1});
        vecs.push_back('{8'h8E, 8'h80, 8'h80, 1});
        vecs.push_back('{8'h8F, 8'h00, 8'h80, 1});
        vecs.push_back('{8'h84, 8'h12, 8'h12, 1});
        vecs.push_back('{8'h85, 8'h00, 8'h00, 1});
        vecs.push_back('{8'hC0, 8'hA5, 8'hA5, 1});
        vecs.push_back('{8'hC1, 8'h00, 8'h00, 1});
        vecs.push_back('{8'h8E, 8'h00, 8'h00, 1});
        vecs.push_back('{8'h8F, 8'h00, 8'h00, 1});
        vecs.push_back('{8'h84, 8'h12, 8'h12, 1});
        vecs.push_back('{8'h85, 8'h00, 8'h12, 1});
        vecs.push_back('{8'h90, 8'h33, 8'h33, 1});
        vecs.push_back('{8'h91, 8'h00, 8'h00, 1});
        vecs.push_back('{8'h86, 8'h15, 8'h15, 1});
        vecs.push_back('{8'h87, 8'h00, 8'h15, 1});
        vecs.push_back('{8'hBE, 8'h55, 8'h00, 0});
        vecs.push_back('{8'h06, 8'h55, 8'h00, 0});
        vecs.push_back('{8'h87, 8'h00, 8'h15, 1});
        vecs.push_back('{8'hC0, 8'hA5, 8'hA5, 1});
        vecs.push_back('{8'hC1, 8'h00, RAM_EXP, 1});
        vecs.push_back('{8'hC3, 8'h00, 8'h00, 1});
        vecs.push_back('{8'h8C, 8'h99, 8'h99, 1});
        vecs.push_back('{8'h8D, 8'h00, 8'h99, 1});
        vecs.push_back('{8'h8A, 8'h07, 8'h07, 1});
        vecs.push_back('{8'h8B, 8'h00, 8'h07, 1});
        vecs.push_back('{8'h88, 8'h12, 8'h12, 1});
        vecs.push_back('{8'h89, 8'h00, 8'h12, 1});

        tick(5);
        rst_n = 1'b1;
        tick(3);
        check("reset xfer_done", {7'b0, xfer_done}, 8'h00);
        check("reset xfer_cmd", xfer_cmd, 8'h00);
        check("reset xfer_data", xfer_data, 8'h00);
        check("reset io hi-z", {7'b0, io}, 8'h01);

        foreach (vecs[i]) begin
            d0 = done_cnt;
            xfer(vecs[i].cmd, vecs[i].wd, rd);
            check($sformatf("v%0d done count", i), 8'(done_cnt - d0), 8'(vecs[i].done));
            if (vecs[i].done != 0) begin
                check($sformatf("v%0d xfer_cmd", i), last_cmd, vecs[i].cmd);
                check($sformatf("v%0d xfer_data", i), last_data, vecs[i].exp);
            end
            if (vecs[i].cmd[0])
                check($sformatf("v%0d read", i), rd, vecs[i].exp);
        end

        // Start the clock by clearing CH, then read back before the next tick.
        wait_phase(50);
        d0 = done_cnt;
        xfer(8'h80, 8'h45, rd);
        check("sec write done count", 8'(done_cnt - d0), 8'h01);
        check("sec write xfer_cmd", last_cmd, 8'h80);
        check("sec write xfer_data", last_data, 8'h45);
        rd_chk("sec readback", 8'h81, 8'h45);

        // One tick from 00:59:59 rolls into 01:00:00.
        wait_phase(50);
        xfer(8'h84, 8'h00, rd);
        xfer(8'h82, 8'h59, rd);
        xfer(8'h80, 8'h59, rd);
        wait_phase(100);
        rd_chk("rollover sec", 8'h81, 8'h00);
        rd_chk("rollover min", 8'h83, 8'h00);
        rd_chk("rollover hour", 8'h85, 8'h01);
        xfer(8'h80, 8'h80, rd);
        rd_chk("halted sec", 8'h81, 8'h80);

        // Abort a date write after 12 rises.
        d0 = done_cnt;
        ce = 1'b1;
        tick(H);
        send(8'h86, 8);
        send(8'h77, 4);
        host_oe = 1'b0;
        tick(H);
        ce = 1'b0;
        tick(4);
        check("abort io hi-z", {7'b0, io}, 8'h01);
        tick(2 * H);
        check("abort done count", 8'(done_cnt - d0), 8'h00);
        rd_chk("abort date kept", 8'h87, 8'h15);

        read_extra("overrun sec", 8'h81, 8'h80);
        read_extra("overrun ctrl", 8'h8F, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
